// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_tx and uart_rx.
//   - uart_state_t     : receiver/transmitter FSM state encoding
//   - UART_DATA_BITS   : data bits per 8N1 frame
//   - calc_clks_per_bit: clock cycles per bit, rounded to nearest
//   - UART_CLKS_PER_BIT: default for a 50 MHz clock at 115200 baud (434)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_HZ    = 50_000_000;
  localparam int UART_BAUD      = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  // Round to the nearest whole cycle so the bit period error stays below
  // half a clock.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int UART_CLKS_PER_BIT = calc_clks_per_bit(UART_CLK_HZ, UART_BAUD);

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial input and the received-byte outputs of uart_rx.
//   i_Rx_Serial : serial line into the receiver (idles high)
//   o_Rx_DV     : one-cycle strobe, o_Rx_Byte valid in that cycle
//   o_Rx_Byte   : last correctly framed byte
//   o_Rx_Active : receiver is busy with a frame
//   o_Frame_Err : one-cycle strobe on a low stop bit
// Modports: slave = the receiver itself, master = the line driver / consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      i_Rx_Serial;
  logic                      o_Rx_DV;
  logic [UART_DATA_BITS-1:0] o_Rx_Byte;
  logic                      o_Rx_Active;
  logic                      o_Frame_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Frame_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Frame_Err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   i_Clock : system clock
//   i_Rst   : synchronous active-high reset
//   din     : asynchronous input
//   dout    : synchronized output, two cycles late
// Both flops reset to 1 (line idle) so reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Rst,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_reg;

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

  assign dout = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   CLKS_PER_BIT : clock cycles per bit (>= 4)
//   i_Clock      : system clock, rising edge
//   i_Rst        : synchronous active-high reset
//   rx           : uart_rx_if.slave (serial in, byte/strobe/status out)
// The start bit is re-checked at its middle; every later bit is then sampled
// one full bit period apart, i.e. in the middle of each bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic     i_Clock,
  input  logic     i_Rst,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  logic rx_bit;

  uart_state_t               state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [IW-1:0]             idx_reg, idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [UART_DATA_BITS-1:0] byte_reg, byte_next;
  logic                      dv_reg, dv_next;
  logic                      ferr_reg, ferr_next;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Rst   (i_Rst),
    .din     (rx.i_Rx_Serial),
    .dout    (rx_bit)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      byte_reg  <= '0;
      dv_reg    <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      byte_reg  <= byte_next;
      dv_reg    <= dv_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    byte_next  = byte_reg;
    dv_next    = 1'b0;
    ferr_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_bit) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end

      ST_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next = '0;
          if (!rx_bit) begin
            state_next = ST_DATA;
            idx_next   = '0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start.
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_bit;
          if (idx_reg == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (rx_bit) begin
            byte_next  = shift_reg;
            dv_next    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = ST_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        // A held-low line (break) must go high before a new start is accepted.
        if (rx_bit) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx.o_Rx_DV     = dv_reg;
  assign rx.o_Rx_Byte   = byte_reg;
  assign rx.o_Frame_Err = ferr_reg;
  assign rx.o_Rx_Active = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// A behavioural line driver plays the role of uart_tx; expectations come from
// the frames the bench itself builds (byte delivered only when the stop bit
// is 1, frame error otherwise).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst   (rst),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Monitor: counts strobes, records delivered bytes and their cycle numbers,
  // and flags any strobe that overlaps or repeats on consecutive cycles.
  int          dv_cnt    = 0;
  int          ferr_cnt  = 0;
  int          bad_pulse = 0;
  longint      cyc       = 0;
  logic [7:0]  got_q[$];
  longint      dv_cyc_q[$];
  logic        prev_pulse = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_if.o_Rx_DV === 1'b1) begin
      dv_cnt++;
      got_q.push_back(rx_if.o_Rx_Byte);
      dv_cyc_q.push_back(cyc);
    end
    if (rx_if.o_Frame_Err === 1'b1) ferr_cnt++;
    if (rx_if.o_Rx_DV === 1'b1 && rx_if.o_Frame_Err === 1'b1) bad_pulse++;
    if (prev_pulse && (rx_if.o_Rx_DV === 1'b1 || rx_if.o_Frame_Err === 1'b1)) bad_pulse++;
    prev_pulse = (rx_if.o_Rx_DV === 1'b1) || (rx_if.o_Frame_Err === 1'b1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Hold the line at v for n clock cycles; returns 1 time unit after an edge.
  task automatic drive_bit(input logic v, input int n);
    rx_if.i_Rx_Serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) drive_bit(frame[k], CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         low_after;
    int         exp_dv;
    int         exp_ferr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         dv0, f0, exp_ferr;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       sb;

    vecs[0] = '{8'hA5, 1'b1, 0,  1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b0, 20, 0, 1, 8'hA5};
    vecs[2] = '{8'h11, 1'b1, 0,  1, 0, 8'h11};
    vecs[3] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C};
    vecs[4] = '{8'hFF, 1'b0, 5,  0, 1, 8'h3C};
    vecs[5] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};

    rx_if.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(1'b1, 2);

    // Reset state
    check("reset_dv",     rx_if.o_Rx_DV,     0);
    check("reset_byte",   rx_if.o_Rx_Byte,   0);
    check("reset_active", rx_if.o_Rx_Active, 0);
    check("reset_ferr",   rx_if.o_Frame_Err, 0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      dv0 = dv_cnt;
      f0  = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      if (vecs[i].low_after > 0) drive_bit(1'b0, vecs[i].low_after);
      drive_bit(1'b1, 4);
      check($sformatf("vec%0d_dv", i),     dv_cnt - dv0,       vecs[i].exp_dv);
      check($sformatf("vec%0d_ferr", i),   ferr_cnt - f0,      vecs[i].exp_ferr);
      check($sformatf("vec%0d_byte", i),   rx_if.o_Rx_Byte,    vecs[i].exp_byte);
      check($sformatf("vec%0d_active", i), rx_if.o_Rx_Active,  0);
    end

    // Glitch: two low cycles are rejected, next frame is received
    dv0 = dv_cnt;
    f0  = ferr_cnt;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 1);
    check("glitch_active_seen", rx_if.o_Rx_Active, 1);
    drive_bit(1'b1, 10);
    check("glitch_active_idle", rx_if.o_Rx_Active, 0);
    check("glitch_dv",   dv_cnt - dv0,  0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1, 4);
    check("after_glitch_dv",   dv_cnt - dv0,    1);
    check("after_glitch_byte", rx_if.o_Rx_Byte, 8'h3C);

    // Break after a bad stop bit: stays busy, no restart while low
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, 4);
    dv0 = dv_cnt;
    f0  = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    drive_bit(1'b0, 20);
    check("break_ferr",   ferr_cnt - f0,     1);
    check("break_dv",     dv_cnt - dv0,      0);
    check("break_byte",   rx_if.o_Rx_Byte,   8'hA5);
    check("break_active", rx_if.o_Rx_Active, 1);
    drive_bit(1'b1, 4);
    check("break_released", rx_if.o_Rx_Active, 0);
    send_frame(8'h11, 1'b1);
    drive_bit(1'b1, 4);
    check("after_break_dv",   dv_cnt - dv0,    1);
    check("after_break_byte", rx_if.o_Rx_Byte, 8'h11);

    // Back-to-back frames, zero idle time
    dv0 = dv_cnt;
    got_q.delete();
    dv_cyc_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 4);
    check("b2b_dv", dv_cnt - dv0, 2);
    if (got_q.size() == 2 && dv_cyc_q.size() == 2) begin
      check("b2b_byte0",   got_q[0],                   8'h00);
      check("b2b_byte1",   got_q[1],                   8'hFF);
      check("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], 10 * CPB);
    end

    // Reset during data bit 4 aborts the frame
    dv0 = dv_cnt;
    f0  = ferr_cnt;
    b   = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int k = 0; k < 4; k++) drive_bit(b[k], CPB);
    drive_bit(b[4], CPB / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_if.i_Rx_Serial = 1'b1;
    check("rst_mid_dv",     rx_if.o_Rx_DV,     0);
    check("rst_mid_byte",   rx_if.o_Rx_Byte,   0);
    check("rst_mid_active", rx_if.o_Rx_Active, 0);
    check("rst_mid_ferr",   rx_if.o_Frame_Err, 0);
    drive_bit(1'b1, 2 * CPB);
    check("rst_abort_dv",   dv_cnt - dv0,  0);
    check("rst_abort_ferr", ferr_cnt - f0, 0);
    send_frame(8'h7E, 1'b1);
    drive_bit(1'b1, 4);
    check("after_rst_dv",   dv_cnt - dv0,    1);
    check("after_rst_byte", rx_if.o_Rx_Byte, 8'h7E);

    // Randomized: loopback of every byte value with random idle gaps, then
    // random bytes with occasional bad stop bits.
    got_q.delete();
    f0       = ferr_cnt;
    exp_ferr = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      drive_bit(1'b1, $urandom_range(0, 3));
    end
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(b, sb);
      if (sb) begin
        exp_q.push_back(b);
        drive_bit(1'b1, $urandom_range(0, 3));
      end else begin
        exp_ferr++;
        drive_bit(1'b1, CPB + $urandom_range(0, 3));
      end
    end
    drive_bit(1'b1, 4);
    check("rand_count", got_q.size(),  exp_q.size());
    check("rand_ferr",  ferr_cnt - f0, exp_ferr);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    end

    check("pulse_rules", bad_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
